// File: rtl/ir_ctrl_pkg.sv
// Shared types and constants for the IR decision sequencer.
package ir_ctrl_pkg;

    localparam int ANSWER_W = 3;
    localparam int LIGHT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        EVAL,
        GAP
    } state_t;

    localparam logic [LIGHT_W-1:0] LIGHTS_OFF     = 4'b0000;
    localparam logic [LIGHT_W-1:0] LIGHTS_1       = 4'b0001;
    localparam logic [LIGHT_W-1:0] LIGHTS_2       = 4'b0010;
    localparam logic [LIGHT_W-1:0] LIGHTS_3       = 4'b0100;
    localparam logic [LIGHT_W-1:0] LIGHTS_4       = 4'b1000;
    localparam logic [LIGHT_W-1:0] LIGHTS_INVALID = 4'b1111;

endpackage

// File: rtl/ir_light_map.sv
// Combinational decoder from a decision answer to its IR light pattern.
module ir_light_map
    import ir_ctrl_pkg::*;
(
    input  logic [ANSWER_W-1:0] answer,
    output logic [LIGHT_W-1:0]  lights
);

    always_comb begin
        lights = LIGHTS_INVALID;
        case (answer)
            3'd0:    lights = LIGHTS_OFF;
            3'd1:    lights = LIGHTS_1;
            3'd2:    lights = LIGHTS_2;
            3'd3:    lights = LIGHTS_3;
            3'd4:    lights = LIGHTS_4;
            default: lights = LIGHTS_INVALID;
        endcase
    end

endmodule

// File: rtl/ir_decision_sequencer.sv
// Measurement sequencer with answer confirmation driving the IR light bank.
// Optional watchdog on the WAIT state is enabled by defining IR_TIMEOUT_EN.
module ir_decision_sequencer
    import ir_ctrl_pkg::*;
#(
    parameter int CONFIRM_COUNT  = 3,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                meas_start,
    input  logic                meas_done,
    input  logic [ANSWER_W-1:0] meas_answer,
    output logic [LIGHT_W-1:0]  ir_lights,
    output logic [ANSWER_W-1:0] answer,
    output logic                answer_valid,
    output logic                busy,
    output logic                timeout_flag
);

    localparam int             GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]     CONF     = 4'(CONFIRM_COUNT);

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [ANSWER_W-1:0] cap_q, cap_d;
    logic [ANSWER_W-1:0] cand_q, cand_d;
    logic [3:0]          match_q, match_d;
    logic                meas_start_q, meas_start_d;
    logic [LIGHT_W-1:0]  ir_lights_q, ir_lights_d;
    logic [ANSWER_W-1:0] answer_q, answer_d;
    logic                answer_valid_q, answer_valid_d;
    logic                busy_q, busy_d;
    logic [LIGHT_W-1:0]  map_lights;

`ifdef IR_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_flag_q, timeout_flag_d;
`endif

    ir_light_map u_map (
        .answer (cap_q),
        .lights (map_lights)
    );

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        cap_d          = cap_q;
        cand_d         = cand_q;
        match_d        = match_q;
        ir_lights_d    = ir_lights_q;
        answer_d       = answer_q;
        meas_start_d   = 1'b0;
        answer_valid_d = 1'b0;
`ifdef IR_TIMEOUT_EN
        wd_d           = wd_q;
        timeout_flag_d = timeout_flag_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d      = START;
                    meas_start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef IR_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT: begin
                // A done strobe wins over a simultaneous watchdog expiry.
                if (meas_done) begin
                    cap_d   = meas_answer;
                    state_d = EVAL;
`ifdef IR_TIMEOUT_EN
                    timeout_flag_d = 1'b0;
                end else if (wd_q == WD_LAST) begin
                    state_d        = GAP;
                    gap_d          = '0;
                    timeout_flag_d = 1'b1;
                    match_d        = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            EVAL: begin
                state_d = GAP;
                gap_d   = '0;
                if (cap_q == cand_q) begin
                    if (match_q != CONF) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == CONF) begin
                            answer_d       = cap_q;
                            ir_lights_d    = map_lights;
                            answer_valid_d = 1'b1;
                        end
                    end
                end else begin
                    cand_d  = cap_q;
                    match_d = 4'd1;
                    if (CONF == 4'd1) begin
                        answer_d       = cap_q;
                        ir_lights_d    = map_lights;
                        answer_valid_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            gap_q          <= '0;
            cap_q          <= '0;
            cand_q         <= '0;
            match_q        <= '0;
            meas_start_q   <= 1'b0;
            ir_lights_q    <= LIGHTS_OFF;
            answer_q       <= '0;
            answer_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            cap_q          <= cap_d;
            cand_q         <= cand_d;
            match_q        <= match_d;
            meas_start_q   <= meas_start_d;
            ir_lights_q    <= ir_lights_d;
            answer_q       <= answer_d;
            answer_valid_q <= answer_valid_d;
            busy_q         <= busy_d;
        end
    end

`ifdef IR_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q           <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            wd_q           <= wd_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign meas_start   = meas_start_q;
    assign ir_lights    = ir_lights_q;
    assign answer       = answer_q;
    assign answer_valid = answer_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ir_decision_sequencer.sv
// Bench for ir_decision_sequencer: directed and random measurements vs. a history-based model.
module tb_ir_decision_sequencer;

    localparam int CONF = 3;
    localparam int GAPC = 4;
    localparam int TMO  = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       meas_start;
    logic       meas_done = 1'b0;
    logic [2:0] meas_answer = 3'd0;
    logic [3:0] ir_lights;
    logic [2:0] answer;
    logic       answer_valid;
    logic       busy;
    logic       timeout_flag;

    int tests = 0;
    int fails = 0;

    int         hist[$];
    logic       exp_pulse;
    logic [2:0] exp_ans = 3'd0;
    logic [3:0] exp_lights = 4'd0;

    ir_decision_sequencer #(
        .CONFIRM_COUNT  (CONF),
        .GAP_CYCLES     (GAPC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .meas_start   (meas_start),
        .meas_done    (meas_done),
        .meas_answer  (meas_answer),
        .ir_lights    (ir_lights),
        .answer       (answer),
        .answer_valid (answer_valid),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] light_of(input int a);
        if (a == 0) return 4'd0;
        if (a < 5)  return 4'(1 << (a - 1));
        return 4'hF;
    endfunction

    // Confirmation happens exactly when the trailing run of identical answers reaches CONF.
    task automatic model_meas(input int a);
        int run;
        hist.push_back(a);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == a) run++;
            else break;
        end
        exp_pulse = (run == CONF);
        if (exp_pulse) begin
            exp_ans    = 3'(a);
            exp_lights = light_of(a);
        end
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (meas_start) begin
                got = 1'b1;
                break;
            end
        end
        chk("start_seen", 32'(got), 32'd1);
    endtask

    task automatic do_meas(input int a, input int dly);
        bit got;
        wait_start(got);
        if (!got) return;
        chk("busy_start", 32'(busy), 32'd1);
        repeat (1 + dly) @(negedge clock);
        meas_done   = 1'b1;
        meas_answer = 3'(a);
        @(negedge clock);
        meas_done   = 1'b0;
        meas_answer = 3'($urandom);
        model_meas(a);
        @(negedge clock);
        chk("valid_pulse", 32'(answer_valid), 32'(exp_pulse));
        chk("answer", 32'(answer), 32'(exp_ans));
        chk("lights", 32'(ir_lights), 32'(exp_lights));
        chk("tmo_clear", 32'(timeout_flag), 32'd0);
        @(negedge clock);
        chk("valid_one_cycle", 32'(answer_valid), 32'd0);
        // A strobe during GAP must be ignored.
        meas_done   = 1'b1;
        meas_answer = 3'($urandom);
        @(negedge clock);
        meas_done = 1'b0;
    endtask

    initial begin
        bit got;
        int a, prev, cnt;

        repeat (3) @(negedge clock);
        chk("rst_start", 32'(meas_start), 32'd0);
        chk("rst_lights", 32'(ir_lights), 32'd0);
        chk("rst_answer", 32'(answer), 32'd0);
        chk("rst_valid", 32'(answer_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(timeout_flag), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        do_meas(2, 1); do_meas(2, 0); do_meas(2, 3);
        do_meas(1, 2); do_meas(1, 0); do_meas(3, 1); do_meas(3, 4); do_meas(3, 0);
        do_meas(6, 0); do_meas(6, 2); do_meas(6, 1);
        do_meas(6, 0);

        prev = 0;
        for (int k = 0; k < 24; k++) begin
            a = ($urandom_range(0, 2) != 0) ? prev : int'($urandom_range(0, 7));
            prev = a;
            do_meas(a, int'($urandom_range(0, 5)));
        end

        // Drop enable while waiting; the measurement still completes.
        wait_start(got);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        meas_done   = 1'b1;
        meas_answer = 3'd4;
        @(negedge clock);
        meas_done = 1'b0;
        model_meas(4);
        @(negedge clock);
        chk("drop_valid", 32'(answer_valid), 32'(exp_pulse));
        chk("drop_lights", 32'(ir_lights), 32'(exp_lights));
        repeat (GAPC + 2) @(negedge clock);
        chk("drop_busy", 32'(busy), 32'd0);
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (meas_start) cnt++;
        end
        chk("drop_no_start", 32'(cnt), 32'd0);
        chk("drop_retain", 32'(answer), 32'(exp_ans));
        enable = 1'b1;

        // Reset arriving during the confirming EVAL cycle.
        do_meas(5, 0); do_meas(5, 0);
        wait_start(got);
        @(negedge clock);
        meas_done   = 1'b1;
        meas_answer = 3'd5;
        @(negedge clock);
        meas_done = 1'b0;
        reset     = 1'b1;
        #1;
        chk("evrst_valid", 32'(answer_valid), 32'd0);
        chk("evrst_lights", 32'(ir_lights), 32'd0);
        chk("evrst_answer", 32'(answer), 32'd0);
        chk("evrst_busy", 32'(busy), 32'd0);
        chk("evrst_start", 32'(meas_start), 32'd0);
        @(negedge clock);
        chk("evrst_valid2", 32'(answer_valid), 32'd0);
        hist.delete();
        exp_ans    = 3'd0;
        exp_lights = 4'd0;
        reset = 1'b0;
        do_meas(5, 1); do_meas(5, 0); do_meas(5, 2);

`ifdef IR_TIMEOUT_EN
        wait_start(got);
        cnt = 0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clock);
            if (timeout_flag) begin
                cnt = n;
                break;
            end
        end
        chk("tmo_latency_ok", 32'(cnt >= 49 && cnt <= 52), 32'd1);
        chk("tmo_lights", 32'(ir_lights), 32'(exp_lights));
        hist.delete();
        do_meas(5, 0); do_meas(5, 0); do_meas(5, 0);
`else
        repeat (3 * TMO) @(negedge clock);
        chk("tmo_absent", 32'(timeout_flag), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
